// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronised rx line, mid-bit sampling timed from a
// half-bit divider latched at start detection, with framing/overrun reporting.
module uart_rx #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] clock_div,
    input  logic        rx,
    input  logic        rx_ack,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_error,
    output logic        rx_overrun,
    output logic        rx_busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t                 state, state_next;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rs;
    logic [15:0]            div_q, div_next, div_sel;
    logic [16:0]            timer, timer_next, bit_reload;
    logic [2:0]             idx, idx_next;
    logic [7:0]             shift, shift_next, data_next;
    logic                   valid_next, error_next, overrun_next;
    logic                   expired;

    // Preset to 1 so the line reads idle straight out of reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) sync_q <= '1;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end

    assign rs         = sync_q[SYNC_STAGES-1];
    assign div_sel    = (clock_div < 16'd2) ? 16'd2 : clock_div;
    assign bit_reload = {div_q, 1'b0} - 17'd1;
    assign expired    = (timer == '0);
    assign rx_busy    = (state != IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            div_q      <= 16'd2;
            timer      <= '0;
            idx        <= '0;
            shift      <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_error   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            state      <= state_next;
            div_q      <= div_next;
            timer      <= timer_next;
            idx        <= idx_next;
            shift      <= shift_next;
            rx_data    <= data_next;
            rx_valid   <= valid_next;
            rx_error   <= error_next;
            rx_overrun <= overrun_next;
        end
    end

    always_comb begin
        state_next   = state;
        div_next     = div_q;
        timer_next   = expired ? timer : timer - 17'd1;
        idx_next     = idx;
        shift_next   = shift;
        data_next    = rx_data;
        valid_next   = rx_valid & ~rx_ack;
        error_next   = 1'b0;
        overrun_next = 1'b0;

        case (state)
            IDLE: begin
                if (!rs) begin
                    state_next = START;
                    div_next   = div_sel;
                    timer_next = {1'b0, div_sel} - 17'd1;
                end
            end
            START: begin
                if (expired) begin
                    if (rs) begin
                        state_next = IDLE;
                    end else begin
                        state_next = DATA;
                        idx_next   = '0;
                        timer_next = bit_reload;
                    end
                end
            end
            DATA: begin
                if (expired) begin
                    shift_next[idx] = rs;
                    timer_next      = bit_reload;
                    if (idx == 3'd7) state_next = STOP;
                    else             idx_next   = idx + 3'd1;
                end
            end
            STOP: begin
                if (expired) begin
                    if (rs) begin
                        // A completing byte outranks a simultaneous ack.
                        data_next    = shift;
                        valid_next   = 1'b1;
                        overrun_next = rx_valid & ~rx_ack;
                        state_next   = IDLE;
                    end else begin
                        error_next = 1'b1;
                        state_next = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rs) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a serial line model pushes expected bytes,
// a negedge monitor pops and compares them when the receiver reports a byte.
module tb_uart_rx;

    localparam int SYNC = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] clock_div = 16'd217;
    logic        rx = 1'b1;
    logic        rx_ack = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_error, rx_overrun, rx_busy;

    uart_rx #(.SYNC_STAGES(SYNC)) dut (
        .clock      (clock),
        .reset      (reset),
        .clock_div  (clock_div),
        .rx         (rx),
        .rx_ack     (rx_ack),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_error   (rx_error),
        .rx_overrun (rx_overrun),
        .rx_busy    (rx_busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] data;
        logic       ovr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, errors = 0;
    int   cyc = 0, start_cyc = 0, evt_cyc = 0;
    int   err_count = 0, ovr_count = 0, evt_count = 0;
    bit   auto_ack = 1'b1, ack_hold = 1'b0, ack_pending = 1'b0, prev_valid = 1'b0;
    bit   model_valid = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    function automatic int period(input int d);
        return 2 * ((d < 2) ? 2 : d);
    endfunction

    // Monitor: detects byte completions, compares against the scoreboard, drives acks.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (!reset) begin
            prev_valid  = 1'b0;
            ack_pending = 1'b0;
            rx_ack      = 1'b0;
        end else begin
            if (ack_pending) begin
                check("ack_clears_valid", rx_valid, 0);
                ack_pending = 1'b0;
            end
            if ((rx_valid && !prev_valid) || rx_overrun) begin
                evt_count++;
                evt_cyc = cyc;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte actual=%0h expected=none at cycle %0d", rx_data, cyc);
                end else begin
                    e = sb.pop_front();
                    check("rx_data", rx_data, e.data);
                    check("rx_overrun_flag", rx_overrun, e.ovr);
                end
            end
            if (rx_overrun) ovr_count++;
            if (rx_error)   err_count++;
            rx_ack      = ack_hold || (auto_ack && rx_valid);
            ack_pending = rx_valid && (ack_hold || auto_ack);
            prev_valid  = rx_valid;
        end
    end

    // Line model: one 8N1 frame of p cycles per bit; optionally retunes clock_div after the start bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int p, input int new_div);
        logic [9:0] bits;
        exp_t       e;
        bits = {stop_bit, b, 1'b0};
        if (stop_bit) begin
            e.data = b;
            e.ovr  = model_valid && !auto_ack && !ack_hold;
            sb.push_back(e);
            model_valid = !auto_ack && !ack_hold;
        end
        start_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            repeat (p) @(negedge clock);
            if (i == 0 && new_div >= 0) clock_div = new_div[15:0];
        end
    endtask

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin : stimulus
        logic [7:0] msg [4];
        logic [7:0] v;
        int         base_err, base_evt, base_ovr, exp_err, lat, p, d, nd;
        logic       good;

        msg[0] = 8'h41; msg[1] = 8'h44; msg[2] = 8'h41; msg[3] = 8'h4D;

        repeat (3) @(negedge clock);
        check("reset_data", rx_data, 0);
        check("reset_valid", rx_valid, 0);
        check("reset_error", rx_error, 0);
        check("reset_overrun", rx_overrun, 0);
        check("reset_busy", rx_busy, 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // Single byte at 115200-style timing, checked for latency and ack.
        send_frame(8'h41, 1'b1, 434, -1);
        repeat (10) @(negedge clock);
        lat = evt_cyc - start_cyc;
        check("latency_in_window", int'(lat >= 434 * 19 / 2 && lat <= 434 * 19 / 2 + SYNC + 3), 1);
        check("first_data_held", rx_data, 8'h41);
        check("first_valid_acked", rx_valid, 0);
        check("first_no_error", err_count, 0);

        // Back-to-back frames with a single stop bit.
        foreach (msg[i]) send_frame(msg[i], 1'b1, 434, -1);
        repeat (20) @(negedge clock);
        check("b2b_drained", sb.size(), 0);
        check("b2b_event_count", evt_count, 5);

        // Short low glitch on an idle line.
        base_err = err_count;
        base_evt = evt_count;
        rx = 1'b0;
        repeat (50) @(negedge clock);
        check("glitch_busy", rx_busy, 1);
        repeat (50) @(negedge clock);
        rx = 1'b1;
        repeat (130) @(negedge clock);
        check("glitch_idle", rx_busy, 0);
        check("glitch_valid", rx_valid, 0);
        check("glitch_data", rx_data, 8'h4D);
        check("glitch_no_error", err_count, base_err);
        check("glitch_no_byte", evt_count, base_evt);
        repeat (434) @(negedge clock);

        // Framing error followed by a held-low line.
        send_frame(8'h55, 1'b0, 434, -1);
        repeat (3 * 434) @(negedge clock);
        check("break_busy", rx_busy, 1);
        rx = 1'b1;
        repeat (10) @(negedge clock);
        check("break_released", rx_busy, 0);
        check("break_one_error", err_count, base_err + 1);
        check("break_no_valid", rx_valid, 0);
        check("break_no_byte", evt_count, base_evt);
        check("break_data_kept", rx_data, 8'h4D);
        repeat (434) @(negedge clock);

        // Overrun: two bytes without ack.
        auto_ack    = 1'b0;
        model_valid = 1'b0;
        base_ovr    = ovr_count;
        send_frame(8'h12, 1'b1, 434, -1);
        send_frame(8'h34, 1'b1, 434, -1);
        repeat (5) @(negedge clock);
        check("overrun_once", ovr_count - base_ovr, 1);
        check("overrun_data", rx_data, 8'h34);
        check("overrun_valid", rx_valid, 1);
        check("overrun_drained", sb.size(), 0);
        auto_ack    = 1'b1;
        model_valid = 1'b0;
        repeat (3) @(negedge clock);
        check("late_ack_clears", rx_valid, 0);

        // Reset in the middle of data bit 4 of 0xA5.
        v  = 8'hA5;
        rx = 1'b0;
        repeat (434) @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            rx = v[i];
            repeat (434) @(negedge clock);
        end
        rx = v[4];
        repeat (217) @(negedge clock);
        check("busy_mid_frame", rx_busy, 1);
        #2 reset = 1'b0;
        #1;
        check("midreset_data", rx_data, 0);
        check("midreset_valid", rx_valid, 0);
        check("midreset_busy", rx_busy, 0);
        check("midreset_error", rx_error, 0);
        check("midreset_overrun", rx_overrun, 0);
        @(negedge clock);
        rx = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        model_valid = 1'b0;
        repeat (5) @(negedge clock);
        send_frame(8'h3C, 1'b1, 434, -1);
        repeat (10) @(negedge clock);
        check("post_reset_data", rx_data, 8'h3C);
        check("post_reset_drained", sb.size(), 0);

        // Ack held high: each completing byte must still raise rx_valid.
        clock_div = 16'd3;
        ack_hold  = 1'b1;
        repeat (2) @(negedge clock);
        send_frame(8'($urandom), 1'b1, 6, -1);
        send_frame(8'($urandom), 1'b1, 6, -1);
        repeat (5) @(negedge clock);
        ack_hold = 1'b0;
        check("ack_hold_drained", sb.size(), 0);

        // Randomised frames: small and sub-minimum dividers, mid-frame divider
        // changes, occasional framing errors, random inter-frame gaps.
        base_err = err_count;
        exp_err  = 0;
        for (int n = 0; n < 40; n++) begin
            d = int'($urandom_range(0, 6));
            clock_div = d[15:0];
            p = period(d);
            @(negedge clock);
            good = ($urandom_range(0, 4) != 0);
            nd   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 8)) : -1;
            send_frame(8'($urandom), good, p, nd);
            if (!good) begin
                exp_err++;
                repeat (p * int'($urandom_range(0, 2))) @(negedge clock);
                rx = 1'b1;
            end
            repeat (p * int'($urandom_range(0, 2)) + 2) @(negedge clock);
        end
        repeat (20) @(negedge clock);
        check("random_drained", sb.size(), 0);
        check("random_errors", err_count - base_err, exp_err);
        check("final_idle", rx_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive half of the UART: 8N1 asynchronous serial (1 start, 8 data LSB first, 1 stop, idle high) deserialised into bytes.
- Shares the transmitter's clock, reset and clock_div, so one clock_div setting gives matching TX and RX baud rates.
- Typical use: console input path; in loopback benches it sits directly on the transmitter's tx line.

Parameters:
- SYNC_STAGES, 2, flip-flops in the rx input synchroniser (minimum 2).

Ports:
- clock  input  1  system clock; all logic on the rising edge
- reset  input  1  asynchronous, active-low reset
- clock_div  input  16  half bit period in clock cycles; bit period = 2*clock_div (217 -> 434 cycles = 115200 baud at 50 MHz)
- rx  input  1  serial line, asynchronous to clock, idle high
- rx_ack  input  1  consumer acknowledges rx_data; clears rx_valid
- rx_data  output  8  last received byte, held until the next good byte
- rx_valid  output  1  high from byte completion until acked
- rx_error  output  1  one-cycle pulse on framing error (stop bit sampled low)
- rx_overrun  output  1  one-cycle pulse when a good byte completes while rx_valid is already high
- rx_busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE; rx_data = 0x00; rx_valid, rx_error, rx_overrun, rx_busy = 0.
  - All synchroniser flops preset to 1 so the line reads idle.
- The synchronised line rs is the output of SYNC_STAGES flops on rx. All decisions use rs only.
- clock_div is latched at start detection. Values below 2 are treated as 2. Changing clock_div mid-frame has no effect on the current frame.
- The timer is 17 bits and counts clock cycles.
- State machine:
  - IDLE: when rs = 0, go to START, load timer = latched div - 1, rx_busy = 1.
  - START: on timer expiry (start-bit midpoint), sample rs:
    - rs = 1: glitch; return to IDLE with no output activity.
    - rs = 0: go to DATA, bit index = 0, timer = 2*div - 1.
  - DATA: on each expiry, shift rs into bit[index], LSB first, and reload timer = 2*div - 1. After index 7, go to STOP.
  - STOP: on expiry, sample rs:
    - rs = 1: rx_data <= shift register; rx_valid <= 1; pulse rx_overrun if rx_valid was already 1. The new data overwrites the old. Go to IDLE.
    - rs = 0: pulse rx_error; rx_data and rx_valid are unchanged; go to BREAK.
  - BREAK: wait until rs = 1, then go to IDLE. This prevents a held-low line from being decoded as 0x00 bytes.
- Outputs rx_valid, rx_error and rx_overrun change in the cycle after the stop-bit sample.
- rx_ack:
  - rx_ack = 1 clears rx_valid on the next edge.
  - If rx_ack coincides with a new byte completing, the new byte wins: rx_valid stays 1, rx_data is updated, and no overrun is flagged.
  - rx_ack while rx_valid = 0 is ignored.
- IDLE to START needs only a low level on rs, not an edge. After STOP succeeds the line is already high, so back-to-back frames with a single stop bit are received without loss.
- Reset asserted mid-frame aborts immediately. Partial data is discarded and no pulse is emitted.

Test Plan:
- Reset, then clock_div=217 and rx driven by a bit-accurate model at 434 cycles/bit with byte 0x41:
  - rx_data=0x41, rx_valid rises about 9.5 bit periods after the start edge, rx_error=0.
  - Then ack: rx_valid drops on the next edge.
- Bytes 0x41, 0x44, 0x41, 0x4D sent back-to-back (one stop bit, no gap), each acked:
  - Four rx_valid rises with exactly those values.
  - Also loop the existing transmitter's tx into rx and get the same result.
- A 100-cycle low glitch on idle rx:
  - Returns to IDLE at the half-bit sample; rx_valid, rx_error and rx_data unchanged.
- Frame 0x55 with the stop bit forced low, line held low for 3 bit times, then released:
  - One rx_error pulse, no rx_valid, no further bytes, rx_busy=0 after release.
- 0x12 then 0x34 with no ack:
  - rx_overrun pulses once at the second completion; rx_data=0x34, rx_valid=1.
- reset pulled low during data bit 4 of 0xA5:
  - All outputs go to 0 at once.
  - After release, a following 0x3C is received correctly.
